// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared funct3 codes, FSM states and access size mask
// Purpose: common definitions for the load/store access unit.
// Ports: none (package).
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [7:0] size_mask(input logic [2:0] funct3);
    logic [7:0] m;
    case (funct3[1:0])
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline-side and bus-side handshake interfaces
// Purpose: bundles the request/response channel from the pipeline and the
//          data-memory bus channel of the access unit.
// mem_pipe_if: req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//              rsp_valid/rsp_ready/rsp_rdata/rsp_fault.
//              master = pipeline, slave = access unit.
// mem_bus_if:  bus_req_valid/bus_req_ready/bus_we/bus_addr/bus_be/bus_wdata,
//              bus_rsp_valid/bus_rdata.
//              master = access unit, slave = memory.
interface mem_pipe_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

interface mem_bus_if #(
  parameter int XLEN = 32
);
  localparam int NBYTES = XLEN / 8;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [NBYTES-1:0] bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_rsp_valid;
  logic [XLEN-1:0]   bus_rdata;

  modport master (
    output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_req_ready, bus_rsp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_req_ready, bus_rsp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// rtl/mem_access_unit_load_extend.sv - load lane shift plus sign/zero extension
// Purpose: combinational extraction of a loaded value from a bus word.
// Ports: i_data   - XLEN bus word (or merged split-access word)
//        i_offset - byte offset of the access inside i_data
//        i_funct3 - load funct3 (size in [1:0], unsigned in [2])
//        o_data   - extended XLEN result
module mem_load_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]                i_data,
  input  logic [$clog2(XLEN/8)-1:0]      i_offset,
  input  logic [2:0]                     i_funct3,
  output logic [XLEN-1:0]                o_data
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_mask;
  logic            w_sign;

  always_comb begin
    int nbits;
    w_shifted = i_data >> {i_offset, 3'b000};
    nbits     = 8 << i_funct3[1:0];
    w_mask    = '0;
    w_sign    = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      w_mask[i] = (i < nbits);
      if (i == nbits - 1) w_sign = w_shifted[i];
    end
    // A full-XLEN access has an all-ones mask, so ~w_mask adds nothing.
    o_data = w_shifted & w_mask;
    if (!i_funct3[2] && w_sign) o_data = o_data | ~w_mask;
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access unit between pipeline and data bus
// Purpose: accepts one load/store at a time, drives a lane-aligned bus beat,
//          and returns extended load data or a fault.
// Ports: clk, rst_n (async active-low)
//        pipe - mem_pipe_if.slave (request/response from the pipeline)
//        bus  - mem_bus_if.master (data-memory bus)
// Option: MEM_ACCESS_MISALIGN_EN - split word-crossing misaligned accesses
//         into two bus beats instead of faulting them.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_pipe_if.slave  pipe,
  mem_bus_if.master  bus
);

  localparam int NBYTES = XLEN / 8;
  localparam int OFFW   = $clog2(NBYTES);

  localparam logic [1:0] S_IDLE     = 2'(IDLE);
  localparam logic [1:0] S_BUS_REQ  = 2'(BUS_REQ);
  localparam logic [1:0] S_BUS_WAIT = 2'(BUS_WAIT);
  localparam logic [1:0] S_RESP     = 2'(RESP);

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           ((XLEN == 64) && (f3 == F3_D));
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU) ||
           ((XLEN == 64) && ((f3 == F3_D) || (f3 == F3_WU)));
    end
    return ok;
  endfunction

  // Lane mask over two consecutive words; upper selects the second word.
  function automatic logic [NBYTES-1:0] lane_mask(input logic [2:0] f3,
                                                 input logic [OFFW-1:0] off,
                                                 input logic upper);
    logic [2*NBYTES-1:0] wide;
    wide = (2*NBYTES)'(size_mask(f3)) << off;
    return upper ? wide[2*NBYTES-1:NBYTES] : wide[NBYTES-1:0];
  endfunction

  function automatic logic [XLEN-1:0] lane_data(input logic [XLEN-1:0] d,
                                               input logic [OFFW-1:0] off,
                                               input logic upper);
    logic [2*XLEN-1:0] wide;
    wide = {{XLEN{1'b0}}, d} << {off, 3'b000};
    return upper ? wide[2*XLEN-1:XLEN] : wide[XLEN-1:0];
  endfunction

  logic [1:0]        r_state;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_off;
  logic [XLEN-1:0]   r_rsp_rdata;
  logic              r_rsp_fault;
  logic              r_bus_we;
  logic [XLEN-1:0]   r_bus_addr;
  logic [NBYTES-1:0] r_bus_be;
  logic [XLEN-1:0]   r_bus_wdata;

  logic [OFFW-1:0]   w_req_off;
  logic              w_req_legal;
  logic              w_req_misal;
  logic              w_req_fault;
  logic [XLEN-1:0]   w_ext_in;
  logic [OFFW-1:0]   w_ext_off;
  logic [XLEN-1:0]   w_ext_data;

  assign w_req_off   = pipe.req_addr[OFFW-1:0];
  assign w_req_legal = f3_legal(pipe.req_we, pipe.req_funct3);
  assign w_req_misal = (w_req_off & OFFW'((4'd1 << pipe.req_funct3[1:0]) - 4'd1)) != '0;

`ifdef MEM_ACCESS_MISALIGN_EN
  logic              r_split;
  logic              r_beat;
  logic [XLEN-1:0]   r_stage;
  logic [XLEN-1:0]   r_wdata;
  logic              w_req_cross;

  function automatic logic [XLEN-1:0] merge_beats(input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo,
                                                 input logic [OFFW-1:0] off);
    logic [2*XLEN-1:0] wide;
    wide = {hi, lo} >> {off, 3'b000};
    return wide[XLEN-1:0];
  endfunction

  assign w_req_cross = w_req_misal &&
                       ((int'(w_req_off) + (1 << int'(pipe.req_funct3[1:0]))) > NBYTES);
  assign w_req_fault = !w_req_legal;
  // Merged split data is already LSB-aligned, so it is extended at offset 0.
  assign w_ext_in    = r_split ? merge_beats(bus.bus_rdata, r_stage, r_off) : bus.bus_rdata;
  assign w_ext_off   = r_split ? '0 : r_off;
`else
  assign w_req_fault = !w_req_legal || w_req_misal;
  assign w_ext_in    = bus.bus_rdata;
  assign w_ext_off   = r_off;
`endif

  mem_load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_data   (w_ext_in),
    .i_offset (w_ext_off),
    .i_funct3 (r_funct3),
    .o_data   (w_ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
`ifdef MEM_ACCESS_MISALIGN_EN
      r_split     <= 1'b0;
      r_beat      <= 1'b0;
      r_stage     <= '0;
      r_wdata     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pipe.req_valid) begin
            r_we        <= pipe.req_we;
            r_funct3    <= pipe.req_funct3;
            r_off       <= w_req_off;
            r_rsp_rdata <= '0;
            r_rsp_fault <= w_req_fault;
            if (w_req_fault) begin
              r_state <= S_RESP;
            end else begin
              r_state     <= S_BUS_REQ;
              r_bus_we    <= pipe.req_we;
              r_bus_addr  <= {pipe.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              r_bus_wdata <= lane_data(pipe.req_wdata, w_req_off, 1'b0);
`ifdef MEM_ACCESS_MISALIGN_EN
              r_wdata     <= pipe.req_wdata;
              r_split     <= w_req_cross;
              r_beat      <= 1'b0;
              // Single-beat loads read the whole word; split beats carry only their lanes.
              r_bus_be    <= (pipe.req_we || w_req_cross) ?
                             lane_mask(pipe.req_funct3, w_req_off, 1'b0) : '1;
`else
              r_bus_be    <= pipe.req_we ? lane_mask(pipe.req_funct3, w_req_off, 1'b0) : '1;
`endif
            end
          end
        end
        S_BUS_REQ: begin
          if (bus.bus_req_ready) r_state <= S_BUS_WAIT;
        end
        S_BUS_WAIT: begin
          if (bus.bus_rsp_valid) begin
`ifdef MEM_ACCESS_MISALIGN_EN
            if (r_split && !r_beat) begin
              r_beat      <= 1'b1;
              r_stage     <= bus.bus_rdata;
              r_bus_addr  <= r_bus_addr + XLEN'(NBYTES);
              r_bus_be    <= lane_mask(r_funct3, r_off, 1'b1);
              r_bus_wdata <= lane_data(r_wdata, r_off, 1'b1);
              r_state     <= S_BUS_REQ;
            end else
`endif
            begin
              if (!r_we) r_rsp_rdata <= w_ext_data;
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (pipe.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pipe.req_ready    = (r_state == S_IDLE);
  assign pipe.rsp_valid    = (r_state == S_RESP);
  assign pipe.rsp_rdata    = r_rsp_rdata;
  assign pipe.rsp_fault    = r_rsp_fault;
  assign bus.bus_req_valid = (r_state == S_BUS_REQ);
  assign bus.bus_we        = r_bus_we;
  assign bus.bus_addr      = r_bus_addr;
  assign bus.bus_be        = r_bus_be;
  assign bus.bus_wdata     = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit (XLEN=32)
module tb_mem_access_unit;

  localparam int XLEN = 32;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_pipe_if #(.XLEN(XLEN)) pif ();
  mem_bus_if  #(.XLEN(XLEN)) bif ();

  mem_access_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pipe  (pif.slave),
    .bus   (bif.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  bus_t        bus_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rdata_q[$];
  int          bus_stall = 0;
  bit          hold_rsp  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] rd);
    bus_q.push_back('{we, a, be, wd});
    rdata_q.push_back(rd);
  endtask

  task automatic exp_rsp(input logic [31:0] rd, input logic f);
    rsp_q.push_back('{rd, f});
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    int n = 0;
    @(posedge clk); #1;
    pif.req_valid  = 1'b1;
    pif.req_we     = we;
    pif.req_funct3 = f3;
    pif.req_addr   = a;
    pif.req_wdata  = wd;
    do begin @(negedge clk); n++; end while (pif.req_ready !== 1'b1 && n < 40);
    check("req_ready_seen", pif.req_ready, 1);
    @(posedge clk); #1;
    pif.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (pif.rsp_valid !== 1'b1 && n < 40);
    check(name, n, lat);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"},     pif.req_ready,     1);
    check({tag, "_rsp_valid"},     pif.rsp_valid,     0);
    check({tag, "_rsp_fault"},     pif.rsp_fault,     0);
    check({tag, "_rsp_rdata"},     pif.rsp_rdata,     0);
    check({tag, "_bus_req_valid"}, bif.bus_req_valid, 0);
    check({tag, "_bus_we"},        bif.bus_we,        0);
    check({tag, "_bus_addr"},      bif.bus_addr,      0);
    check({tag, "_bus_be"},        bif.bus_be,        0);
    check({tag, "_bus_wdata"},     bif.bus_wdata,     0);
  endtask

  // Bus responder: one-cycle read data / write ack after each accepted beat.
  initial begin
    bit hs;
    bit stalled;
    bif.bus_req_ready = 1'b1;
    bif.bus_rsp_valid = 1'b0;
    bif.bus_rdata     = '0;
    forever begin
      @(negedge clk);
      hs      = rst_n && bif.bus_req_valid && bif.bus_req_ready;
      stalled = rst_n && bif.bus_req_valid && !bif.bus_req_ready;
      @(posedge clk); #1;
      bif.bus_rsp_valid = hs && !hold_rsp;
      bif.bus_rdata     = (hs && !hold_rsp && rdata_q.size() > 0) ? rdata_q.pop_front() : '0;
      if (stalled && bus_stall > 0) bus_stall--;
      bif.bus_req_ready = (bus_stall == 0);
    end
  end

  // Bus monitor: compares each accepted beat and stability while stalled.
  initial begin
    bus_t b;
    bus_t snap;
    bit   stall_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || bif.bus_req_valid !== 1'b1) begin
        stall_seen = 1'b0;
      end else if (bif.bus_req_ready) begin
        stall_seen = 1'b0;
        check("bus_exp_pending", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          b = bus_q.pop_front();
          check("bus_we",    bif.bus_we,    b.we);
          check("bus_addr",  bif.bus_addr,  b.addr);
          check("bus_be",    bif.bus_be,    b.be);
          check("bus_wdata", bif.bus_wdata, b.wdata);
        end
      end else begin
        if (stall_seen) begin
          check("bus_stable_we",    bif.bus_we,    snap.we);
          check("bus_stable_addr",  bif.bus_addr,  snap.addr);
          check("bus_stable_be",    bif.bus_be,    snap.be);
          check("bus_stable_wdata", bif.bus_wdata, snap.wdata);
        end
        snap       = '{bif.bus_we, bif.bus_addr, bif.bus_be, bif.bus_wdata};
        stall_seen = 1'b1;
      end
    end
  end

  // Response monitor: compares each accepted response and stability while stalled.
  initial begin
    rsp_t r;
    rsp_t snap;
    bit   stall_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || pif.rsp_valid !== 1'b1) begin
        stall_seen = 1'b0;
      end else if (pif.rsp_ready) begin
        stall_seen = 1'b0;
        check("rsp_exp_pending", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          check("rsp_rdata", pif.rsp_rdata, r.rdata);
          check("rsp_fault", pif.rsp_fault, r.fault);
        end
      end else begin
        if (stall_seen) begin
          check("rsp_stable_rdata", pif.rsp_rdata, snap.rdata);
          check("rsp_stable_fault", pif.rsp_fault, snap.fault);
        end
        snap       = '{pif.rsp_rdata, pif.rsp_fault};
        stall_seen = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    pif.req_valid  = 1'b0;
    pif.req_we     = 1'b0;
    pif.req_funct3 = 3'b000;
    pif.req_addr   = '0;
    pif.req_wdata  = '0;
    pif.rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LB 0x103: byte 0x80 sign-extended
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'h80AA_BBCC);
    exp_rsp(32'hFFFF_FF80, 1'b0);
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    wait_rsp("lat_lb", 3);

    // LHU / LH 0x102 on 0x9234_5678
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'h9234_5678);
    exp_rsp(32'h0000_9234, 1'b0);
    issue(1'b0, 3'b101, 32'h102, 32'h0);
    wait_rsp("lat_lhu", 3);
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'h9234_5678);
    exp_rsp(32'hFFFF_9234, 1'b0);
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    wait_rsp("lat_lh", 3);

    // LW / LBU
    exp_bus(1'b0, 32'h104, 4'b1111, 32'h0, 32'h1234_5678);
    exp_rsp(32'h1234_5678, 1'b0);
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    wait_rsp("lat_lw", 3);
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'h0000_00F0);
    exp_rsp(32'h0000_00F0, 1'b0);
    issue(1'b0, 3'b100, 32'h100, 32'h0);
    wait_rsp("lat_lbu", 3);

    // Stores: read-data bus value must not leak into the response
    exp_bus(1'b1, 32'h200, 4'b0010, 32'h0000_EF00, 32'hDEAD_BEEF);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h201, 32'h0000_00EF);
    wait_rsp("lat_sb", 3);
    exp_bus(1'b1, 32'h204, 4'b1100, 32'hABCD_0000, 32'hDEAD_BEEF);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h206, 32'h1234_ABCD);
    wait_rsp("lat_sh", 3);
    exp_bus(1'b1, 32'h208, 4'b1111, 32'hCAFE_F00D, 32'hDEAD_BEEF);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h208, 32'hCAFE_F00D);
    wait_rsp("lat_sw", 3);

    // Illegal funct3: no bus traffic, fault one cycle after accept
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 3'b111, 32'h100, 32'h0);
    wait_rsp("lat_f3_111", 1);
    exp_rsp(32'h0, 1'b1);
    issue(1'b1, 3'b100, 32'h100, 32'h5555_5555);
    wait_rsp("lat_store_f3_100", 1);
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    wait_rsp("lat_ld_on_rv32", 1);

`ifdef MEM_ACCESS_MISALIGN_EN
    // Split LW 0x103
    exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 32'h1122_3344);
    exp_bus(1'b0, 32'h104, 4'b0111, 32'h0, 32'h5566_7788);
    exp_rsp(32'h6677_8811, 1'b0);
    issue(1'b0, 3'b010, 32'h103, 32'h0);
    wait_rsp("lat_split_lw", 5);
    // Misaligned LH inside one word: single beat
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'h00AB_CD00);
    exp_rsp(32'hFFFF_ABCD, 1'b0);
    issue(1'b0, 3'b001, 32'h101, 32'h0);
    wait_rsp("lat_inword_lh", 3);
    // Split SW 0x206
    exp_bus(1'b1, 32'h204, 4'b1100, 32'h3344_0000, 32'hDEAD_BEEF);
    exp_bus(1'b1, 32'h208, 4'b0011, 32'h0000_1122, 32'hDEAD_BEEF);
    exp_rsp(32'h0, 1'b0);
    issue(1'b1, 3'b010, 32'h206, 32'h1122_3344);
    wait_rsp("lat_split_sw", 5);
`else
    // Misaligned accesses fault without bus traffic
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h102, 32'h0);
    wait_rsp("lat_misal_lw", 1);
    exp_rsp(32'h0, 1'b1);
    issue(1'b0, 3'b001, 32'h101, 32'h0);
    wait_rsp("lat_misal_lh", 1);
    exp_rsp(32'h0, 1'b1);
    issue(1'b1, 3'b010, 32'h206, 32'h1122_3344);
    wait_rsp("lat_misal_sw", 1);
`endif

    // Bus stalls 5 cycles, response stalls 3 cycles
    bus_stall = 5;
    repeat (2) @(negedge clk);
    check("stall_ready_low", bif.bus_req_ready, 0);
    pif.rsp_ready = 1'b0;
    exp_bus(1'b0, 32'h300, 4'b1111, 32'h0, 32'h0BAD_F00D);
    exp_rsp(32'h0BAD_F00D, 1'b0);
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    wait_rsp("lat_stalled", 8);
    repeat (3) @(posedge clk);
    #1;
    pif.rsp_ready = 1'b1;

    // Reset while waiting for bus data: no response may follow
    hold_rsp = 1'b1;
    bus_q.push_back('{1'b0, 32'h400, 4'b1111, 32'h0});
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("wait_bus_req_valid", bif.bus_req_valid, 0);
    check("wait_rsp_valid", pif.rsp_valid, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    @(posedge clk); #1;
    rst_n    = 1'b1;
    hold_rsp = 1'b0;
    repeat (10) @(negedge clk);
    check_idle("postreset");

    // Recovery: LB 0x105 -> 0x7F positive byte
    exp_bus(1'b0, 32'h104, 4'b1111, 32'h0, 32'h0000_7F00);
    exp_rsp(32'h0000_007F, 1'b0);
    issue(1'b0, 3'b000, 32'h105, 32'h0);
    wait_rsp("lat_recover", 3);

    repeat (5) @(negedge clk);
    check("rsp_q_drained", rsp_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
